// File: rtl/rv64g_l2_line_reader.sv
// L2 line read sequencer: takes a {set, way} request, captures the tag to
// form the line address, and streams the 8 words of the line as
// valid/ready beats, word 0 first.
module rv64g_l2_line_reader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 50,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned WORD_W = 3,
  parameter int unsigned WAY_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [IDX_W-1:0]  req_index_i,
  input  logic [WAY_W-1:0]  req_way_i,
  output logic [IDX_W-1:0]  arr_index_o,
  output logic [WORD_W-1:0] arr_word_sel_o,
  output logic [WAY_W-1:0]  arr_way_sel_o,
  input  logic [DATA_W-1:0] arr_rdata_i,
  input  logic [TAG_W-1:0]  arr_tag_i,
  output logic              beat_valid_o,
  input  logic              beat_ready_i,
  output logic [DATA_W-1:0] beat_data_o,
  output logic [WORD_W-1:0] beat_idx_o,
  output logic              beat_last_o,
  output logic [63:0]       line_addr_o,
  output logic              busy_o
);

  localparam int unsigned LINE_ADDR_W = 64;
  localparam int unsigned OFFSET_W    = 6;
  localparam logic [WORD_W-1:0] LAST_PTR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WAY_W-1:0]  way_q;
  logic [WORD_W-1:0] rd_ptr_q;
  logic              load_c;

  // Output register may take a new word when empty or being drained this cycle
  assign load_c = !beat_valid_o || beat_ready_i;

  // Array address: follow the request while idle, latched line otherwise
  always_comb begin
    arr_index_o    = idx_q;
    arr_way_sel_o  = way_q;
    arr_word_sel_o = rd_ptr_q;
    if (state_q == IDLE) begin
      arr_index_o    = req_index_i;
      arr_way_sel_o  = req_way_i;
      arr_word_sel_o = '0;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      way_q        <= '0;
      rd_ptr_q     <= '0;
      req_ready_o  <= 1'b1;
      beat_valid_o <= 1'b0;
      beat_data_o  <= '0;
      beat_idx_o   <= '0;
      beat_last_o  <= 1'b0;
      line_addr_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            idx_q       <= req_index_i;
            way_q       <= req_way_i;
            line_addr_o <= LINE_ADDR_W'({arr_tag_i, req_index_i, {OFFSET_W{1'b0}}});
            rd_ptr_q    <= '0;
            busy_o      <= 1'b1;
            req_ready_o <= 1'b0;
            state_q     <= READ;
          end
        end
        READ: begin
          if (load_c) begin
            beat_data_o  <= arr_rdata_i;
            beat_idx_o   <= rd_ptr_q;
            beat_last_o  <= (rd_ptr_q == LAST_PTR);
            beat_valid_o <= 1'b1;
            if (rd_ptr_q == LAST_PTR) begin
              state_q <= DRAIN;
            end else begin
              rd_ptr_q <= rd_ptr_q + WORD_W'(1);
            end
          end
        end
        DRAIN: begin
          if (beat_valid_o && beat_ready_i) begin
            beat_valid_o <= 1'b0;
            beat_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            req_ready_o  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv64g_l2_line_reader.sv
// Directed bench for rv64g_l2_line_reader with a combinational array model.
module tb_rv64g_l2_line_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_index_i;
  logic [3:0]  req_way_i;
  logic [7:0]  arr_index_o;
  logic [2:0]  arr_word_sel_o;
  logic [3:0]  arr_way_sel_o;
  logic [63:0] arr_rdata_i;
  logic [49:0] arr_tag_i;
  logic        beat_valid_o;
  logic        beat_ready_i;
  logic [63:0] beat_data_o;
  logic [2:0]  beat_idx_o;
  logic        beat_last_o;
  logic [63:0] line_addr_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  rv64g_l2_line_reader dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_index_i    (req_index_i),
    .req_way_i      (req_way_i),
    .arr_index_o    (arr_index_o),
    .arr_word_sel_o (arr_word_sel_o),
    .arr_way_sel_o  (arr_way_sel_o),
    .arr_rdata_i    (arr_rdata_i),
    .arr_tag_i      (arr_tag_i),
    .beat_valid_o   (beat_valid_o),
    .beat_ready_i   (beat_ready_i),
    .beat_data_o    (beat_data_o),
    .beat_idx_o     (beat_idx_o),
    .beat_last_o    (beat_last_o),
    .line_addr_o    (line_addr_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Array contents: set 0x5A way 3 holds A0+n with tag 0x1234; other lines hold a pattern
  always_comb begin
    if (arr_index_o == 8'h5A && arr_way_sel_o == 4'd3) begin
      arr_rdata_i = 64'hA0 + 64'(arr_word_sel_o);
      arr_tag_i   = 50'h1234;
    end else begin
      arr_rdata_i = 64'h1000_0000 + {48'd0, arr_index_o, arr_way_sel_o, 4'd0} + 64'(arr_word_sel_o);
      arr_tag_i   = 50'h3_0000 + {38'd0, arr_index_o, arr_way_sel_o};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] data, input logic [2:0] idx,
                            input logic last, input logic [63:0] addr);
    check({tag, "_valid"}, 64'(beat_valid_o), 64'd1);
    check({tag, "_data"},  beat_data_o, data);
    check({tag, "_idx"},   64'(beat_idx_o), 64'(idx));
    check({tag, "_last"},  64'(beat_last_o), 64'(last));
    check({tag, "_busy"},  64'(busy_o), 64'd1);
    check({tag, "_addr"},  line_addr_o, addr);
    check({tag, "_rdy"},   64'(req_ready_o), 64'd0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_index_i  = 8'h00;
    req_way_i    = 4'd0;
    beat_ready_i = 1'b0;
    #12;

    // Reset state
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_valid", 64'(beat_valid_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_last",  64'(beat_last_o), 64'd0);
    check("rst_data",  beat_data_o, 64'd0);
    check("rst_idx",   64'(beat_idx_o), 64'd0);
    check("rst_addr",  line_addr_o, 64'd0);

    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Line 1: set 0x5A way 3, consumer always ready
    req_valid_i  = 1'b1;
    req_index_i  = 8'h5A;
    req_way_i    = 4'd3;
    beat_ready_i = 1'b1;
    #1;
    check("idle_arr_idx",  64'(arr_index_o), 64'h5A);
    check("idle_arr_way",  64'(arr_way_sel_o), 64'd3);
    check("idle_arr_word", 64'(arr_word_sel_o), 64'd0);
    tick();  // E0: accepted
    req_valid_i = 1'b0;
    check("l1_acc_busy",  64'(busy_o), 64'd1);
    check("l1_acc_rdy",   64'(req_ready_o), 64'd0);
    check("l1_acc_valid", 64'(beat_valid_o), 64'd0);
    check("l1_acc_addr",  line_addr_o, 64'h48D1680);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_beat($sformatf("l1_b%0d", i), 64'hA0 + 64'(i), 3'(i), (i == 7), 64'h48D1680);
    end
    tick();  // beat 7 handshake
    check("l1_end_valid", 64'(beat_valid_o), 64'd0);
    check("l1_end_busy",  64'(busy_o), 64'd0);
    check("l1_end_last",  64'(beat_last_o), 64'd0);
    check("l1_end_rdy",   64'(req_ready_o), 64'd1);

    // Line 2: set 0x21 way 5 with backpressure on beat 2 and a queued request
    req_valid_i = 1'b1;
    req_index_i = 8'h21;
    req_way_i   = 4'd5;
    tick();  // E0
    req_valid_i = 1'b1;
    req_index_i = 8'h5A;
    req_way_i   = 4'd3;
    check("l2_acc_addr", line_addr_o, 64'hC085_4840);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat($sformatf("l2_b%0d", i), 64'h1000_2150 + 64'(i), 3'(i), 1'b0, 64'hC085_4840);
    end
    beat_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_beat($sformatf("l2_stall%0d", c), 64'h1000_2152, 3'd2, 1'b0, 64'hC085_4840);
      check($sformatf("l2_stall%0d_word", c), 64'(arr_word_sel_o), 64'd3);
    end
    beat_ready_i = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tick();
      check_beat($sformatf("l2_b%0d", i), 64'h1000_2150 + 64'(i), 3'(i), (i == 7), 64'hC085_4840);
    end
    tick();  // beat 7 handshake; held request not taken on this edge
    check("l2_end_rdy",   64'(req_ready_o), 64'd1);
    check("l2_end_valid", 64'(beat_valid_o), 64'd0);
    check("l2_end_busy",  64'(busy_o), 64'd0);
    tick();  // held request accepted
    req_valid_i = 1'b0;
    check("l3_acc_rdy",  64'(req_ready_o), 64'd0);
    check("l3_acc_busy", 64'(busy_o), 64'd1);
    check("l3_acc_addr", line_addr_o, 64'h48D1680);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_beat($sformatf("l3_b%0d", i), 64'hA0 + 64'(i), 3'(i), 1'b0, 64'h48D1680);
    end

    // Asynchronous reset while beat 4 is pending
    beat_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 64'(beat_valid_o), 64'd0);
    check("arst_busy",  64'(busy_o), 64'd0);
    check("arst_last",  64'(beat_last_o), 64'd0);
    check("arst_rdy",   64'(req_ready_o), 64'd1);
    check("arst_addr",  line_addr_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Fresh request after reset restarts at word 0
    req_valid_i  = 1'b1;
    req_index_i  = 8'h21;
    req_way_i    = 4'd5;
    beat_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_beat($sformatf("l4_b%0d", i), 64'h1000_2150 + 64'(i), 3'(i), (i == 7), 64'hC085_4840);
    end
    tick();
    check("l4_end_busy", 64'(busy_o), 64'd0);
    check("l4_end_rdy",  64'(req_ready_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
